// File: rtl/dm_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_resp_pkg
// Description : Shared types and constants for the dm_resp data-memory
//               responder (state encoding, geometry, byte-merge helper).
//               Optional feature macro: DM_RESP_BE_EN (per-byte store enables).
// Revision    : 1.0 - initial release
// ============================================================================
package dm_resp_pkg;

  localparam int DM_ADDR_W  = 10;
  localparam int DM_DEPTH   = 1024;
  localparam int DM_LAT_MAX = 15;
  // Counter width large enough to hold DM_LAT_MAX-1
  localparam int DM_CNT_W   = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } dm_state_e;

  // Replace each enabled byte lane of old_w with the same lane of new_w
  function automatic logic [31:0] dm_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage : dm_resp_pkg
`default_nettype wire

// File: rtl/dm_resp_mem.sv
`default_nettype none
// ============================================================================
// Module      : dm_resp_mem
// Description : Synchronous word memory with byte-write port and a registered
//               read-after-write output. With DM_RESP_BE_EN undefined every
//               store writes the full word and be_i is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_resp_mem
  import dm_resp_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DEPTH  = DM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        be_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [3:0]  be_eff;
  logic [31:0] merged_d;

`ifdef DM_RESP_BE_EN
  assign be_eff = be_i;
`else
  // Word-only build: lanes are always all enabled
  logic unused_be;
  assign unused_be = ^be_i;
  assign be_eff    = 4'hF;
`endif

  // Word as it will look after this store; also the store's response data
  always_comb begin
    merged_d = dm_merge(mem_q[addr_i], wdata_i, be_eff);
  end

  // Array write; contents deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= merged_d;
    end
  end

  // Registered response word, held between accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0;
    end else if (en_i) begin
      rdata_q <= we_i ? merged_d : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : dm_resp_mem
`default_nettype wire

// File: rtl/dm_resp.sv
`default_nettype none
// ============================================================================
// Module      : dm_resp
// Description : Multi-cycle data-memory responder. Accepts one word request
//               over valid/ready, performs it LATENCY edges later and returns
//               a one-cycle response pulse. Legal LATENCY range 1..15.
//               Optional feature macro: DM_RESP_BE_EN (honour req_be).
// Revision    : 1.0 - initial release
// ============================================================================
module dm_resp
  import dm_resp_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = DM_DEPTH,
  parameter int ADDR_W  = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata
);

  localparam logic [DM_CNT_W-1:0] c_LAT_INIT = DM_CNT_W'(LATENCY - 1);

  dm_state_e           state_q;
  logic [DM_CNT_W-1:0] cnt_q;
  logic                ready_q;
  logic                rsp_valid_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic                access_en;

  // Access fires on the edge that leaves BUSY; reset cancels it outright
  assign access_en = (state_q == ST_BUSY) && (cnt_q == '0) && !rst;

  // Request FSM, latency counter, latched request and registered handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && ready_q) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            cnt_q   <= c_LAT_INIT;
            ready_q <= 1'b0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - {{(DM_CNT_W-1){1'b0}}, 1'b1};
          end else begin
            rsp_valid_q <= 1'b1;
            ready_q     <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  dm_resp_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .en_i    (access_en),
    .we_i    (we_q),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (rsp_rdata)
  );

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;

endmodule : dm_resp
`default_nettype wire

// File: tb/tb_dm_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dm_resp
// Description : Self-checking bench for dm_resp. Two instances: LATENCY=2
//               (index 0) and LATENCY=1 (index 1). Expected responses and
//               their arrival times are queued at acceptance and checked
//               when rsp_valid appears. Honours DM_RESP_BE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_resp;

  localparam int PERIOD = 10;
  localparam int LAT0   = 2;
  localparam int LAT1   = 1;

  typedef struct {
    logic [31:0] data;
    time         t;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [9:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata [2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] ref_mem [2][1024];
  int          n_tests;
  int          n_fail;

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  dm_resp #(.LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0])
  );

  dm_resp #(.LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1])
  );

  // Reference store: full word unless byte enables are honoured
  function automatic logic [31:0] model_store(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    logic [3:0]  b;
`ifdef DM_RESP_BE_EN
    b = be;
`else
    b = 4'hF;
`endif
    r = old_w;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // Scoreboard pop and compare on each response pulse
  task automatic check_rsp(input int d);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : q1.size();
    n_tests++;
    if (sz == 0) begin
      n_fail++;
      $display("FAIL unexpected_rsp dut%0d: rsp_valid=1 rdata=%h at %0t, required no response", d, rsp_rdata[d], $time);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      if (rsp_rdata[d] !== e.data) begin
        n_fail++;
        $display("FAIL rsp_data dut%0d: got %h, required %h", d, rsp_rdata[d], e.data);
      end
      n_tests++;
      if ($time !== e.t) begin
        n_fail++;
        $display("FAIL rsp_time dut%0d: got %0t, required %0t", d, $time, e.t);
      end
    end
  endtask

  always @(negedge clk) if (rsp_valid[0] === 1'b1) check_rsp(0);
  always @(negedge clk) if (rsp_valid[1] === 1'b1) check_rsp(1);

  // Present one request, wait (bounded) for acceptance, queue expectation
  task automatic send(input int d, input logic we, input logic [9:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input bit hold, output time t_acc);
    exp_t e;
    int   n;
    int   lat;
    lat = (d == 0) ? LAT0 : LAT1;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: req_ready=%b, required 1 within 50 cycles", d, req_ready[d]);
      req_valid[d] = 1'b0;
      t_acc = 0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    if (we) begin
      ref_mem[d][addr] = model_store(ref_mem[d][addr], wdata, be);
    end
    e.data = ref_mem[d][addr];
    e.t    = $time + lat * PERIOD + PERIOD / 2;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    #1;
    // Fields are free to change once accepted
    req_wdata[d] = $urandom;
    req_be[d]    = 4'($urandom);
    if (!hold) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'($urandom);
      req_addr[d]  = 10'($urandom);
    end
  endtask

  // Wait (bounded) for all outstanding responses of one instance
  task automatic drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL drain_timeout dut%0d: %0d responses outstanding, required 0", d,
               (d == 0) ? q0.size() : q1.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    req_we    = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (req_ready[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_ready dut%0d cyc%0d: got %b, required 1", d, c, req_ready[d]);
        end
        n_tests++;
        if (rsp_valid[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_rsp_valid dut%0d cyc%0d: got %b, required 0", d, c, rsp_valid[d]);
        end
        n_tests++;
        if (rsp_rdata[d] !== 32'h0) begin
          n_fail++;
          $display("FAIL reset_rdata dut%0d cyc%0d: got %h, required 00000000", d, c, rsp_rdata[d]);
        end
      end
    end
  endtask

  task automatic test_store_load();
    time t;
    send(0, 1'b1, 10'h004, 32'hDEADBEEF, 4'hF, 1'b0, t);
    drain(0);
    n_tests++;
    if (rsp_rdata[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL store_rdata: got %h, required deadbeef", rsp_rdata[0]);
    end
    send(0, 1'b0, 10'h004, 32'h0, 4'h0, 1'b0, t);
    drain(0);
    n_tests++;
    if (rsp_rdata[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_rdata: got %h, required deadbeef", rsp_rdata[0]);
    end
  endtask

  task automatic test_byte_merge();
    time         t;
    logic [31:0] want;
`ifdef DM_RESP_BE_EN
    want = 32'hAA22CC44;
`else
    want = 32'h11223344;
`endif
    send(0, 1'b1, 10'h010, 32'hAABBCCDD, 4'hF, 1'b0, t);
    send(0, 1'b1, 10'h010, 32'h11223344, 4'b0101, 1'b0, t);
    send(0, 1'b0, 10'h010, 32'h0, 4'h0, 1'b0, t);
    drain(0);
    n_tests++;
    if (rsp_rdata[0] !== want) begin
      n_fail++;
      $display("FAIL byte_merge: got %h, required %h", rsp_rdata[0], want);
    end
  endtask

  task automatic test_back_to_back();
    time t1, t2, t3;
    int  low;
    send(0, 1'b1, 10'd1, 32'h1111_0001, 4'hF, 1'b0, t1);
    send(0, 1'b1, 10'd2, 32'h2222_0002, 4'hF, 1'b0, t1);
    send(0, 1'b1, 10'd3, 32'h3333_0003, 4'hF, 1'b0, t1);
    drain(0);
    send(0, 1'b0, 10'd1, 32'h0, 4'h0, 1'b1, t1);
    send(0, 1'b0, 10'd2, 32'h0, 4'h0, 1'b1, t2);
    send(0, 1'b0, 10'd3, 32'h0, 4'h0, 1'b1, t3);
    req_valid[0] = 1'b0;
    n_tests++;
    if (t2 - t1 !== time'((LAT0 + 1) * PERIOD)) begin
      n_fail++;
      $display("FAIL b2b_spacing12: got %0t, required %0d", t2 - t1, (LAT0 + 1) * PERIOD);
    end
    n_tests++;
    if (t3 - t2 !== time'((LAT0 + 1) * PERIOD)) begin
      n_fail++;
      $display("FAIL b2b_spacing23: got %0t, required %0d", t3 - t2, (LAT0 + 1) * PERIOD);
    end
    low = 0;
    @(negedge clk);
    while (req_ready[0] !== 1'b1 && low < 20) begin
      low++;
      @(negedge clk);
    end
    n_tests++;
    if (low != LAT0) begin
      n_fail++;
      $display("FAIL b2b_ready_low: got %0d cycles, required %0d", low, LAT0);
    end
    drain(0);
  endtask

  task automatic test_reset_mid();
    time t;
    int  n;
    send(0, 1'b1, 10'h020, 32'h0BADF00D, 4'hF, 1'b0, t);
    drain(0);
    // Store accepted here is aborted; nothing is queued for it
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 10'h020;
    req_wdata[0] = 32'h5555AAAA; req_be[0] = 4'hF;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid_state cyc%0d: rsp_valid=%b req_ready=%b, required 0/1", c, rsp_valid[0], req_ready[0]);
      end
      @(negedge clk);
    end
    send(0, 1'b0, 10'h020, 32'h0, 4'h0, 1'b0, t);
    drain(0);
    n_tests++;
    if (rsp_rdata[0] !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL rst_mid_mem: got %h, required 0badf00d", rsp_rdata[0]);
    end
  endtask

  task automatic test_lat1_wrap();
    time t;
    send(1, 1'b1, 10'h000, 32'hCAFE0000, 4'hF, 1'b0, t);
    send(1, 1'b1, 10'h3FF, 32'h12345678, 4'hF, 1'b0, t);
    send(1, 1'b0, 10'h3FF, 32'h0, 4'h0, 1'b0, t);
    drain(1);
    n_tests++;
    if (rsp_rdata[1] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL lat1_top_word: got %h, required 12345678", rsp_rdata[1]);
    end
    send(1, 1'b0, 10'h000, 32'h0, 4'h0, 1'b0, t);
    drain(1);
    n_tests++;
    if (rsp_rdata[1] !== 32'hCAFE0000) begin
      n_fail++;
      $display("FAIL lat1_addr0: got %h, required cafe0000", rsp_rdata[1]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_store_load();
    test_byte_merge();
    test_back_to_back();
    test_reset_mid();
    test_lat1_wrap();
    repeat (5) @(negedge clk);
    n_tests++;
    if (q0.size() + q1.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d outstanding, required 0", q0.size() + q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dm_resp
`default_nettype wire
